// File: rtl/robo_sequenciador_if.sv
// Sensor, motor and status signals of the wall-follower move sequencer.
// The master modport is the sequencer side; the slave modport is the robot environment side.
interface robo_sequenciador_if;
    logic       start;
    logic       abort;
    logic [7:0] budget;
    logic       sense_req;
    logic       sense_ack;
    logic       head;
    logic       left;
    logic       avancar;
    logic       girar;
    logic       motor_done;
    logic [4:0] row;
    logic [4:0] col;
    logic [1:0] dir;
    logic [7:0] moves_left;
    logic       busy;
    logic       done;
    logic       stuck;

    modport master (
        input  start, abort, budget, sense_ack, head, left, motor_done,
        output sense_req, avancar, girar, row, col, dir, moves_left, busy, done, stuck
    );

    modport slave (
        output start, abort, budget, sense_ack, head, left, motor_done,
        input  sense_req, avancar, girar, row, col, dir, moves_left, busy, done, stuck
    );
endinterface

// File: rtl/robo_sequenciador.sv
// Left-hand-rule move sequencer for the 20x20 grid robot: sense, decide, command, track position.
// Optional macro ROBO_STALL_DETECT_EN enables the spin counter and the stuck exit.
module robo_sequenciador #(
    parameter logic [4:0] START_ROW  = 5'd1,
    parameter logic [4:0] START_COL  = 5'd1,
    parameter logic [1:0] START_DIR  = 2'b00,
    parameter logic [2:0] SPIN_LIMIT = 3'd4
) (
    input  logic                 clock,
    input  logic                 reset,
    robo_sequenciador_if.master  bus
);

    localparam logic [1:0] DIR_N = 2'b00;
    localparam logic [1:0] DIR_S = 2'b01;
    localparam logic [1:0] DIR_L = 2'b10;
    localparam logic [1:0] DIR_O = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SENSE  = 3'd1,
        S_DECIDE = 3'd2,
        S_MOVE   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Quarter turn to the left: N->O->S->L->N.
    function automatic logic [1:0] rotate_left(input logic [1:0] d);
        logic [1:0] res;
        case (d)
            DIR_N:   res = DIR_O;
            DIR_O:   res = DIR_S;
            DIR_S:   res = DIR_L;
            DIR_L:   res = DIR_N;
            default: res = DIR_N;
        endcase
        return res;
    endfunction

    function automatic logic edge_blocked(input logic [4:0] r, input logic [4:0] c, input logic [1:0] d);
        logic res;
        case (d)
            DIR_N:   res = (r == 5'd1);
            DIR_S:   res = (r == 5'd20);
            DIR_L:   res = (c == 5'd20);
            DIR_O:   res = (c == 5'd1);
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    state_t     state_r;
    logic [4:0] row_r;
    logic [4:0] col_r;
    logic [1:0] dir_r;
    logic [7:0] moves_r;
    logic       h_r;
    logic       l_r;
    logic       just_turned_r;
    logic       abort_seen_r;
    logic       sense_req_r;
    logic       avancar_r;
    logic       girar_r;
    logic       busy_r;
    logic       done_r;
    logic       stuck_r;

    logic [4:0] next_row_s;
    logic [4:0] next_col_s;
    logic [1:0] next_dir_s;
    logic [7:0] next_moves_s;
    logic       abort_hit_s;
    logic       stall_hit_s;

    // Position and budget after the command currently on the motor completes.
    always_comb begin
        next_row_s = row_r;
        next_col_s = col_r;
        next_dir_s = dir_r;
        if (girar_r) begin
            next_dir_s = rotate_left(dir_r);
        end else begin
            case (dir_r)
                DIR_N:   next_row_s = row_r - 5'd1;
                DIR_S:   next_row_s = row_r + 5'd1;
                DIR_L:   next_col_s = col_r + 5'd1;
                DIR_O:   next_col_s = col_r - 5'd1;
                default: next_row_s = row_r;
            endcase
        end
        if (moves_r == 8'd0) begin
            next_moves_s = 8'd0;
        end else begin
            next_moves_s = moves_r - 8'd1;
        end
        abort_hit_s = bus.abort | abort_seen_r;
    end

`ifdef ROBO_STALL_DETECT_EN
    logic [2:0] spin_r;
    logic [2:0] next_spin_s;

    // Spin count and stall detection after the pending command completes.
    always_comb begin
        if (girar_r) begin
            next_spin_s = spin_r + 3'd1;
        end else begin
            next_spin_s = 3'd0;
        end
        stall_hit_s = (next_spin_s == SPIN_LIMIT);
    end

    // Consecutive girar counter, cleared by avancar and by each new run.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            spin_r <= 3'd0;
        end else if (((state_r == S_IDLE) || (state_r == S_DONE)) && bus.start) begin
            spin_r <= 3'd0;
        end else if ((state_r == S_MOVE) && bus.motor_done) begin
            spin_r <= next_spin_s;
        end else begin
            spin_r <= spin_r;
        end
    end
`else
    // Without stall detection a run ends only by budget or abort.
    always_comb begin
        stall_hit_s = 1'b0;
    end
`endif

    // Sequencer FSM with registered command and status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= S_IDLE;
            row_r         <= START_ROW;
            col_r         <= START_COL;
            dir_r         <= START_DIR;
            moves_r       <= 8'd0;
            h_r           <= 1'b0;
            l_r           <= 1'b0;
            just_turned_r <= 1'b0;
            abort_seen_r  <= 1'b0;
            sense_req_r   <= 1'b0;
            avancar_r     <= 1'b0;
            girar_r       <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            stuck_r       <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        row_r         <= START_ROW;
                        col_r         <= START_COL;
                        dir_r         <= START_DIR;
                        moves_r       <= bus.budget;
                        stuck_r       <= 1'b0;
                        just_turned_r <= 1'b0;
                        abort_seen_r  <= 1'b0;
                        if (bus.budget == 8'd0) begin
                            state_r     <= S_DONE;
                            sense_req_r <= 1'b0;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                        end else begin
                            state_r     <= S_SENSE;
                            sense_req_r <= 1'b1;
                            busy_r      <= 1'b1;
                            done_r      <= 1'b0;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                S_SENSE: begin
                    if (bus.abort) begin
                        state_r     <= S_DONE;
                        sense_req_r <= 1'b0;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                    end else if (bus.sense_ack) begin
                        // Off-grid neighbours look like walls so the robot never leaves 1..20.
                        h_r         <= bus.head | edge_blocked(row_r, col_r, dir_r);
                        l_r         <= bus.left | edge_blocked(row_r, col_r, rotate_left(dir_r));
                        sense_req_r <= 1'b0;
                        state_r     <= S_DECIDE;
                    end else begin
                        state_r <= S_SENSE;
                    end
                end
                S_DECIDE: begin
                    abort_seen_r <= 1'b0;
                    if (bus.abort) begin
                        state_r <= S_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= S_MOVE;
                        if (!l_r && !just_turned_r) begin
                            girar_r <= 1'b1;
                        end else if (!h_r) begin
                            avancar_r <= 1'b1;
                        end else begin
                            girar_r <= 1'b1;
                        end
                    end
                end
                S_MOVE: begin
                    if (bus.motor_done) begin
                        row_r         <= next_row_s;
                        col_r         <= next_col_s;
                        dir_r         <= next_dir_s;
                        moves_r       <= next_moves_s;
                        just_turned_r <= girar_r;
                        avancar_r     <= 1'b0;
                        girar_r       <= 1'b0;
                        abort_seen_r  <= 1'b0;
                        if (abort_hit_s || (next_moves_s == 8'd0)) begin
                            state_r <= S_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else if (stall_hit_s) begin
                            state_r <= S_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            stuck_r <= 1'b1;
                        end else begin
                            state_r     <= S_SENSE;
                            sense_req_r <= 1'b1;
                        end
                    end else begin
                        // An abort seen mid-command is remembered until the motor finishes.
                        abort_seen_r <= abort_seen_r | bus.abort;
                        state_r      <= S_MOVE;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    sense_req_r <= 1'b0;
                    avancar_r   <= 1'b0;
                    girar_r     <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sense_req  = sense_req_r;
    assign bus.avancar    = avancar_r;
    assign bus.girar      = girar_r;
    assign bus.row        = row_r;
    assign bus.col        = col_r;
    assign bus.dir        = dir_r;
    assign bus.moves_left = moves_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.stuck      = stuck_r;

endmodule

// File: tb/tb_robo_sequenciador.sv
// Randomized bench for robo_sequenciador against a grid-walk reference model.
module tb_robo_sequenciador;

    localparam int START_ROW  = 1;
    localparam int START_COL  = 1;
    localparam int START_DIR  = 0;
    localparam int SPIN_LIMIT = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    robo_sequenciador_if bus();

    robo_sequenciador dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Orientation index N=0 S=1 L=2 O=3: step offsets and the direction to the left.
    int dr [4]      = '{-1, 1, 0, 0};
    int dc [4]      = '{0, 0, 1, -1};
    int left_of [4] = '{3, 2, 0, 1};

    int m_row, m_col, m_dir, m_moves, m_spin;
    bit m_jt, m_stuck;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic bit off_grid(input int r, input int c);
        return (r < 1) || (r > 20) || (c < 1) || (c > 20);
    endfunction

    task automatic check_pos(input string tag);
        check_eq({tag, ".row"}, int'(bus.row), m_row);
        check_eq({tag, ".col"}, int'(bus.col), m_col);
        check_eq({tag, ".dir"}, int'(bus.dir), m_dir);
        check_eq({tag, ".moves_left"}, int'(bus.moves_left), m_moves);
    endtask

    task automatic check_end(input string tag);
        check_eq({tag, ".done"}, int'(bus.done), 1);
        check_eq({tag, ".busy"}, int'(bus.busy), 0);
        check_eq({tag, ".cmd"}, int'(bus.avancar | bus.girar), 0);
        check_eq({tag, ".sense_req"}, int'(bus.sense_req), 0);
        check_eq({tag, ".stuck"}, int'(bus.stuck), int'(m_stuck));
        check_pos(tag);
        tick;
        check_eq({tag, ".done_hold"}, int'(bus.done), 1);
        check_pos({tag, "_hold"});
    endtask

    // mode 0: random sensors, 1: walls ahead and left, 2: open ahead, wall left.
    // ab_stage 0: no abort, 1: in SENSE, 2: in DECIDE, 3: during MOVE.
    task automatic run_one(input int budget, input int mode, input int ab_stage);
        int  ab_k, k, dly;
        bit  ended, exp_turn, h, l, hi, li, ab_now;
        m_row = START_ROW; m_col = START_COL; m_dir = START_DIR;
        m_moves = budget; m_spin = 0; m_jt = 1'b0; m_stuck = 1'b0;
        ab_k = (budget > 0) ? int'($urandom_range(budget - 1, 0)) : 0;
        bus.budget = 8'(budget);
        bus.start  = 1'b1;
        tick;
        bus.start  = 1'b0;
        bus.budget = 8'($urandom);
        if (budget == 0) begin
            check_end("zero_budget");
            return;
        end
        k = 0;
        ended = 1'b0;
        while (!ended) begin
            check_eq("sense_req", int'(bus.sense_req), 1);
            check_eq("busy", int'(bus.busy), 1);
            check_eq("stuck_clear", int'(bus.stuck), 0);
            dly = int'($urandom_range(2, 0));
            for (int i = 0; i < dly; i++) begin
                bus.motor_done = 1'($urandom);
                bus.head       = 1'($urandom);
                bus.left       = 1'($urandom);
                tick;
                check_eq("sense_wait", int'(bus.sense_req), 1);
            end
            bus.motor_done = 1'b0;
            if (ab_stage == 1 && k == ab_k) begin
                bus.abort = 1'b1;
                tick;
                bus.abort = 1'b0;
                check_end("abort_sense");
                ended = 1'b1;
            end else begin
                case (mode)
                    1:       begin hi = 1'b1; li = 1'b1; end
                    2:       begin hi = 1'b0; li = 1'b1; end
                    default: begin hi = 1'($urandom); li = 1'($urandom); end
                endcase
                bus.head = hi;
                bus.left = li;
                bus.sense_ack = 1'b1;
                tick;
                bus.sense_ack = 1'b0;
                bus.head = 1'($urandom);
                bus.left = 1'($urandom);
                h = hi | off_grid(m_row + dr[m_dir], m_col + dc[m_dir]);
                l = li | off_grid(m_row + dr[left_of[m_dir]], m_col + dc[left_of[m_dir]]);
                exp_turn = (!l && !m_jt) || h;
                check_eq("decide_quiet", int'(bus.avancar | bus.girar | bus.sense_req), 0);
                if (ab_stage == 2 && k == ab_k) begin
                    bus.abort = 1'b1;
                    tick;
                    bus.abort = 1'b0;
                    check_end("abort_decide");
                    ended = 1'b1;
                end else begin
                    tick;
                    check_eq("avancar", int'(bus.avancar), int'(!exp_turn));
                    check_eq("girar", int'(bus.girar), int'(exp_turn));
                    if (ab_stage == 3 && k == ab_k) bus.abort = 1'b1;
                    dly = int'($urandom_range(3, 0));
                    for (int i = 0; i < dly; i++) begin
                        bus.start = (i == 0);
                        tick;
                        check_eq("cmd_held", int'({bus.avancar, bus.girar}), exp_turn ? 1 : 2);
                    end
                    bus.start = 1'b0;
                    ab_now = bus.abort;
                    bus.motor_done = 1'b1;
                    tick;
                    bus.motor_done = 1'b0;
                    bus.abort = 1'b0;
                    if (exp_turn) begin
                        m_dir = left_of[m_dir];
                        m_jt = 1'b1;
                        m_spin++;
                    end else begin
                        m_row += dr[m_dir];
                        m_col += dc[m_dir];
                        m_jt = 1'b0;
                        m_spin = 0;
                    end
                    if (m_moves > 0) m_moves--;
                    check_pos("move");
                    if (ab_now || m_moves == 0) ended = 1'b1;
`ifdef ROBO_STALL_DETECT_EN
                    else if (m_spin == SPIN_LIMIT) begin
                        ended = 1'b1;
                        m_stuck = 1'b1;
                    end
`endif
                    if (ended) check_end("run_end");
                    else check_eq("cmd_drop", int'(bus.avancar | bus.girar), 0);
                end
            end
            k++;
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.budget = 8'd0;
        bus.sense_ack = 1'b0; bus.head = 1'b0; bus.left = 1'b0; bus.motor_done = 1'b0;
        tick;
        tick;
        check_eq("rst.row", int'(bus.row), START_ROW);
        check_eq("rst.col", int'(bus.col), START_COL);
        check_eq("rst.dir", int'(bus.dir), START_DIR);
        check_eq("rst.moves_left", int'(bus.moves_left), 0);
        check_eq("rst.flags", int'({bus.sense_req, bus.avancar, bus.girar, bus.busy, bus.done, bus.stuck}), 0);
        reset = 1'b0;
        tick;

        run_one(3, 2, 0);
        run_one(10, 1, 0);
        run_one(0, 0, 0);
        run_one(5, 0, 1);
        run_one(5, 0, 2);
        run_one(5, 2, 3);
        for (int n = 0; n < 40; n++) begin
            run_one(int'($urandom_range(25, 0)), int'($urandom_range(2, 0)), int'($urandom_range(3, 0)));
        end

        // Reset while girar waits on the motor: command drops without a clock edge.
        bus.budget = 8'd5;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        bus.head = 1'b0;
        bus.left = 1'b0;
        bus.sense_ack = 1'b1;
        tick;
        bus.sense_ack = 1'b0;
        tick;
        check_eq("rst_mid.girar_before", int'(bus.girar), 1);
        reset = 1'b1;
        #1;
        check_eq("rst_mid.girar", int'(bus.girar), 0);
        check_eq("rst_mid.busy", int'(bus.busy), 0);
        check_eq("rst_mid.row", int'(bus.row), START_ROW);
        check_eq("rst_mid.col", int'(bus.col), START_COL);
        check_eq("rst_mid.dir", int'(bus.dir), START_DIR);
        check_eq("rst_mid.moves_left", int'(bus.moves_left), 0);
        tick;
        reset = 1'b0;
        tick;
        check_eq("rst_mid.idle", int'({bus.busy, bus.done, bus.sense_req}), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
